btn_input_conditioner: RTL and testbench

BTN_INPUT_CONDITIONER -- requirements
Module: btn_input_conditioner

---
 rtl/btn_input_conditioner_pkg.sv | 14 +
 rtl/btn_input_conditioner_if.sv | 30 +++
 rtl/btn_input_conditioner_debounce.sv | 62 ++++++
 rtl/btn_input_conditioner.sv | 101 ++++++++++
 tb/tb_btn_input_conditioner.sv | 398 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/btn_input_conditioner_pkg.sv
// Shared definitions for the push-button / slide-switch input conditioner:
// button index constants and the event FSM state encoding.
package btn_input_conditioner_pkg;

    localparam int BTN_DATA_A  = 0;
    localparam int BTN_DATA_B  = 1;
    localparam int BTN_OP_CODE = 2;

    typedef enum logic [0:0] {
        IDLE         = 1'b0,
        WAIT_RELEASE = 1'b1
    } cond_state_t;

endpackage

// File: rtl/btn_input_conditioner_if.sv
// Raw board inputs and conditioned event outputs of btn_input_conditioner.
// The conditioner sits on the slave side; whoever drives the raw pins is master.
interface btn_input_conditioner_if #(
    parameter int NB_DATA         = 8,
    parameter int NB_INPUT_SELECT = 3
);

    logic [NB_INPUT_SELECT-1:0] i_btn_raw;
    logic [NB_DATA-1:0]         i_sw_raw;
    logic [NB_INPUT_SELECT-1:0] o_btn;
    logic [NB_DATA-1:0]         o_sw_data;
    logic                       o_valid;

    modport master (
        output i_btn_raw,
        output i_sw_raw,
        input  o_btn,
        input  o_sw_data,
        input  o_valid
    );

    modport slave (
        input  i_btn_raw,
        input  i_sw_raw,
        output o_btn,
        output o_sw_data,
        output o_valid
    );

endinterface

// File: rtl/btn_input_conditioner_debounce.sv
// Single-bit 2-flop synchronizer followed by a stability counter (btn_debounce).
// Counter only exists when BTN_COND_DEBOUNCE_EN is defined; otherwise state = synchronized input.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clock,
    input  logic i_rst_n,
    input  logic raw_i,
    output logic state_o
);

    logic syncMeta_q;
    logic syncOut_q;

    always_ff @(posedge clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            syncMeta_q <= 1'b0;
            syncOut_q  <= 1'b0;
        end else begin
            syncMeta_q <= raw_i;
            syncOut_q  <= syncMeta_q;
        end
    end

`ifdef BTN_COND_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             deb_q;
    logic             deb_d;

    // Any sample agreeing with the debounced level restarts the stability count.
    always_comb begin
        count_d = '0;
        deb_d   = deb_q;
        if (syncOut_q != deb_q) begin
            if (count_q == CNT_LAST) begin
                deb_d = syncOut_q;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_q <= '0;
            deb_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            deb_q   <= deb_d;
        end
    end

    assign state_o = deb_q;
`else
    assign state_o = syncOut_q;
`endif

endmodule

// File: rtl/btn_input_conditioner.sv
// Turns bouncing buttons and raw switches into single-cycle load events for the operand registers.
// Build with BTN_COND_DEBOUNCE_EN defined to enable the per-button debounce counters.
module btn_input_conditioner
    import btn_input_conditioner_pkg::*;
#(
    parameter int NB_DATA         = 8,
    parameter int NB_INPUT_SELECT = 3,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                     clock,
    input  logic                     i_rst_n,
    btn_input_conditioner_if.slave   bus
);

    logic [NB_DATA-1:0]         swMeta_q;
    logic [NB_DATA-1:0]         swSync_q;
    logic [NB_INPUT_SELECT-1:0] deb;
    logic [NB_INPUT_SELECT-1:0] debPrev_q;
    logic [NB_INPUT_SELECT-1:0] rise_q;
    logic [NB_INPUT_SELECT-1:0] firstRise;

    cond_state_t                state_q;
    cond_state_t                state_d;
    logic                       valid_q;
    logic                       valid_d;
    logic [NB_INPUT_SELECT-1:0] btnSel_q;
    logic [NB_INPUT_SELECT-1:0] btnSel_d;
    logic [NB_DATA-1:0]         swData_q;
    logic [NB_DATA-1:0]         swData_d;

    for (genvar i = 0; i < NB_INPUT_SELECT; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clock   (clock),
            .i_rst_n (i_rst_n),
            .raw_i   (bus.i_btn_raw[i]),
            .state_o (deb[i])
        );
    end

    // Rising edges are registered so the event lands a fixed number of edges after the debounced change.
    always_ff @(posedge clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            swMeta_q  <= '0;
            swSync_q  <= '0;
            debPrev_q <= '0;
            rise_q    <= '0;
        end else begin
            swMeta_q  <= bus.i_sw_raw;
            swSync_q  <= swMeta_q;
            debPrev_q <= deb;
            rise_q    <= deb & ~debPrev_q;
        end
    end

    // Two's-complement trick isolates the lowest-index rising button.
    assign firstRise = rise_q & (~rise_q + 1'b1);

    always_comb begin
        state_d  = state_q;
        valid_d  = 1'b0;
        btnSel_d = '0;
        swData_d = swData_q;
        case (state_q)
            IDLE: begin
                if (|rise_q) begin
                    valid_d  = 1'b1;
                    btnSel_d = firstRise;
                    swData_d = swSync_q;
                    state_d  = WAIT_RELEASE;
                end
            end
            WAIT_RELEASE: begin
                if (deb == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            valid_q  <= 1'b0;
            btnSel_q <= '0;
            swData_q <= '0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            btnSel_q <= btnSel_d;
            swData_q <= swData_d;
        end
    end

    assign bus.o_valid   = valid_q;
    assign bus.o_btn     = btnSel_q;
    assign bus.o_sw_data = swData_q;

endmodule

// File: tb/tb_btn_input_conditioner.sv
// Self-checking bench for btn_input_conditioner: directed scenarios plus randomized bouncing,
// all compared cycle by cycle against a sliding-window reference model.
module tb_btn_input_conditioner;

    localparam int NB_DATA = 8;
    localparam int NB_SEL  = 3;
    localparam int DEB     = 4;
    localparam int HIST    = DEB + 4;
`ifdef BTN_COND_DEBOUNCE_EN
    localparam bit DEB_ON = 1'b1;
`else
    localparam bit DEB_ON = 1'b0;
`endif
    localparam int LAT = DEB_ON ? DEB + 3 : 3;

    logic clock;
    logic i_rst_n;
    int   total;
    int   bad;

    btn_input_conditioner_if #(.NB_DATA(NB_DATA), .NB_INPUT_SELECT(NB_SEL)) bus ();

    btn_input_conditioner #(
        .NB_DATA         (NB_DATA),
        .NB_INPUT_SELECT (NB_SEL),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clock   (clock),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: histories of raw samples, newest at index 0.
    logic [NB_SEL-1:0]  rawQ[$];
    logic [NB_DATA-1:0] swQ[$];
    logic [NB_SEL-1:0]  debQ[$];
    bit                 mIdle;
    logic               expValid;
    logic [NB_SEL-1:0]  expBtn;
    logic [NB_DATA-1:0] expSw;

    task automatic modelReset();
        rawQ.delete();
        swQ.delete();
        debQ.delete();
        for (int i = 0; i < HIST; i++) begin
            rawQ.push_back('0);
            swQ.push_back('0);
            debQ.push_back('0);
        end
        mIdle    = 1'b1;
        expValid = 1'b0;
        expBtn   = '0;
        expSw    = '0;
    endtask

    // A button's level flips once its input (seen two edges late) has differed for DEB edges in a row;
    // a rise is reported two edges after the debounced flip if no earlier press is still held.
    task automatic modelEdge(input logic [NB_SEL-1:0] b, input logic [NB_DATA-1:0] s);
        logic [NB_SEL-1:0] nextDeb;
        logic [NB_SEL-1:0] rise;
        bit                allDiff;
        rawQ.push_front(b);
        void'(rawQ.pop_back());
        swQ.push_front(s);
        void'(swQ.pop_back());
        nextDeb = debQ[0];
        if (DEB_ON) begin
            for (int k = 0; k < NB_SEL; k++) begin
                allDiff = 1'b1;
                for (int j = 0; j < DEB; j++)
                    if (rawQ[2 + j][k] == debQ[0][k]) allDiff = 1'b0;
                if (allDiff) nextDeb[k] = ~debQ[0][k];
            end
        end else begin
            nextDeb = rawQ[1];
        end
        debQ.push_front(nextDeb);
        void'(debQ.pop_back());
        rise     = debQ[2] & ~debQ[3];
        expValid = 1'b0;
        expBtn   = '0;
        if (mIdle) begin
            if (rise != '0) begin
                expValid = 1'b1;
                for (int k = NB_SEL - 1; k >= 0; k--) begin
                    if (rise[k]) begin
                        expBtn    = '0;
                        expBtn[k] = 1'b1;
                    end
                end
                expSw = swQ[2];
                mIdle = 1'b0;
            end
        end else if (debQ[1] == '0) begin
            mIdle = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        if (i_rst_n) modelEdge(bus.i_btn_raw, bus.i_sw_raw);
        @(negedge clock);
    endtask

    task automatic applyStimulus(input logic [NB_SEL-1:0] b, input logic [NB_DATA-1:0] s);
        bus.i_btn_raw = b;
        bus.i_sw_raw  = s;
    endtask

    task automatic applyReset();
        i_rst_n = 1'b0;
        bus.i_btn_raw = '0;
        modelReset();
        repeat (3) tick();
        i_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        applyStimulus('0, '0);
        modelReset();
        repeat (2) tick();
        total++;
        if ({bus.o_valid, bus.o_btn, bus.o_sw_data} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_state got %b/%b/%h want 0/000/00", bus.o_valid, bus.o_btn, bus.o_sw_data);
        end
        i_rst_n = 1'b1;
        applyStimulus(3'b010, 8'h5A);
        for (int c = 0; c < LAT + 3; c++) begin
            tick();
            total++;
            if ({bus.o_valid, bus.o_btn, bus.o_sw_data} !== {expValid, expBtn, expSw}) begin
                bad++;
                $display("[TB] FAIL reset_pre c=%0d got %b/%b/%h want %b/%b/%h", c,
                         bus.o_valid, bus.o_btn, bus.o_sw_data, expValid, expBtn, expSw);
            end
        end
        total++;
        if (bus.o_sw_data !== 8'h5A) begin
            bad++;
            $display("[TB] FAIL reset_capture got %h want 5a", bus.o_sw_data);
        end
        #2 i_rst_n = 1'b0;
        #1;
        total++;
        if ({bus.o_valid, bus.o_btn, bus.o_sw_data} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_async got %b/%b/%h want 0/000/00", bus.o_valid, bus.o_btn, bus.o_sw_data);
        end
        modelReset();
        applyStimulus('0, '0);
        repeat (2) tick();
        i_rst_n = 1'b1;
    endtask

    task automatic test_clean_press();
        int firstEdge;
        int nEv;
        logic [NB_SEL-1:0]  evBtn;
        logic [NB_DATA-1:0] evSw;
        firstEdge = -1;
        nEv = 0;
        evBtn = '0;
        evSw = '0;
        applyReset();
        applyStimulus(3'b001, 8'hA5);
        for (int c = 0; c < LAT + 12; c++) begin
            if (c == LAT + 4) applyStimulus(3'b000, 8'hA5);
            tick();
            total++;
            if ({bus.o_valid, bus.o_btn, bus.o_sw_data} !== {expValid, expBtn, expSw}) begin
                bad++;
                $display("[TB] FAIL clean_press c=%0d got %b/%b/%h want %b/%b/%h", c,
                         bus.o_valid, bus.o_btn, bus.o_sw_data, expValid, expBtn, expSw);
            end
            if (bus.o_valid === 1'b1) begin
                nEv++;
                if (firstEdge < 0) firstEdge = c;
                evBtn = bus.o_btn;
                evSw  = bus.o_sw_data;
            end
        end
        total++;
        if (firstEdge != LAT || nEv != 1) begin
            bad++;
            $display("[TB] FAIL clean_latency got edge=%0d events=%0d want edge=%0d events=1", firstEdge, nEv, LAT);
        end
        total++;
        if (evBtn !== 3'b001 || evSw !== 8'hA5) begin
            bad++;
            $display("[TB] FAIL clean_payload got %b/%h want 001/a5", evBtn, evSw);
        end
    endtask

    task automatic test_bounce();
        logic [NB_SEL-1:0] pattern[$];
        int nEv;
        logic [NB_SEL-1:0] evBtn;
        nEv = 0;
        evBtn = '0;
        applyReset();
        pattern = '{3'b010, 3'b000, 3'b010, 3'b000};
        repeat (14) pattern.push_back(3'b010);
        repeat (14) pattern.push_back(3'b000);
        foreach (pattern[c]) begin
            applyStimulus(pattern[c], 8'h33);
            tick();
            total++;
            if ({bus.o_valid, bus.o_btn, bus.o_sw_data} !== {expValid, expBtn, expSw}) begin
                bad++;
                $display("[TB] FAIL bounce c=%0d got %b/%b/%h want %b/%b/%h", c,
                         bus.o_valid, bus.o_btn, bus.o_sw_data, expValid, expBtn, expSw);
            end
            if (bus.o_valid === 1'b1) begin
                nEv++;
                evBtn = bus.o_btn;
            end
        end
`ifdef BTN_COND_DEBOUNCE_EN
        total++;
        if (nEv != 1 || evBtn !== 3'b010) begin
            bad++;
            $display("[TB] FAIL bounce_events got n=%0d btn=%b want n=1 btn=010", nEv, evBtn);
        end
`endif
    endtask

    task automatic test_glitch();
        int nEv;
        nEv = 0;
        applyReset();
        for (int c = 0; c < 18; c++) begin
            applyStimulus((c < 3) ? 3'b010 : 3'b000, 8'h77);
            tick();
            total++;
            if ({bus.o_valid, bus.o_btn, bus.o_sw_data} !== {expValid, expBtn, expSw}) begin
                bad++;
                $display("[TB] FAIL glitch c=%0d got %b/%b/%h want %b/%b/%h", c,
                         bus.o_valid, bus.o_btn, bus.o_sw_data, expValid, expBtn, expSw);
            end
            if (bus.o_valid === 1'b1) nEv++;
        end
        total++;
        if (nEv != (DEB_ON ? 0 : 1)) begin
            bad++;
            $display("[TB] FAIL glitch_events got %0d want %0d", nEv, DEB_ON ? 0 : 1);
        end
    endtask

    task automatic test_simultaneous();
        logic [NB_SEL-1:0] phases[5];
        logic [NB_SEL-1:0] events[$];
        phases = '{3'b101, 3'b100, 3'b000, 3'b100, 3'b000};
        applyReset();
        foreach (phases[p]) begin
            for (int c = 0; c < 14; c++) begin
                applyStimulus(phases[p], 8'hC0 + 8'(p));
                tick();
                total++;
                if ({bus.o_valid, bus.o_btn, bus.o_sw_data} !== {expValid, expBtn, expSw}) begin
                    bad++;
                    $display("[TB] FAIL simultaneous p=%0d c=%0d got %b/%b/%h want %b/%b/%h", p, c,
                             bus.o_valid, bus.o_btn, bus.o_sw_data, expValid, expBtn, expSw);
                end
                if (bus.o_valid === 1'b1) events.push_back(bus.o_btn);
            end
        end
        total++;
        if (events.size() != 2) begin
            bad++;
            $display("[TB] FAIL simultaneous_count got %0d want 2", events.size());
        end else begin
            total++;
            if (events[0] !== 3'b001 || events[1] !== 3'b100) begin
                bad++;
                $display("[TB] FAIL simultaneous_order got %b,%b want 001,100", events[0], events[1]);
            end
        end
    endtask

    task automatic test_reset_mid_press();
        int nEv;
        int firstEdge;
        nEv = 0;
        firstEdge = -1;
        applyReset();
        applyStimulus(3'b001, 8'h96);
        repeat (2) tick();
        #2 i_rst_n = 1'b0;
        #1;
        total++;
        if ({bus.o_valid, bus.o_btn, bus.o_sw_data} !== '0) begin
            bad++;
            $display("[TB] FAIL midpress_async got %b/%b/%h want 0/000/00", bus.o_valid, bus.o_btn, bus.o_sw_data);
        end
        modelReset();
        repeat (3) tick();
        i_rst_n = 1'b1;
        for (int c = 0; c < LAT + 14; c++) begin
            if (c == LAT + 5) applyStimulus(3'b000, 8'h96);
            tick();
            total++;
            if ({bus.o_valid, bus.o_btn, bus.o_sw_data} !== {expValid, expBtn, expSw}) begin
                bad++;
                $display("[TB] FAIL midpress c=%0d got %b/%b/%h want %b/%b/%h", c,
                         bus.o_valid, bus.o_btn, bus.o_sw_data, expValid, expBtn, expSw);
            end
            if (bus.o_valid === 1'b1) begin
                nEv++;
                if (firstEdge < 0) firstEdge = c;
            end
        end
        total++;
        if (nEv != 1 || firstEdge != LAT) begin
            bad++;
            $display("[TB] FAIL midpress_event got n=%0d edge=%0d want n=1 edge=%0d", nEv, firstEdge, LAT);
        end
    endtask

    task automatic test_switch_idle();
        applyReset();
        for (int c = 0; c < 40; c++) begin
            if (c < 12)      applyStimulus(3'b001, 8'h11);
            else if (c < 24) applyStimulus(3'b000, 8'h11);
            else             applyStimulus(3'b000, NB_DATA'($urandom));
            tick();
            total++;
            if ({bus.o_valid, bus.o_btn, bus.o_sw_data} !== {expValid, expBtn, expSw}) begin
                bad++;
                $display("[TB] FAIL switch_idle c=%0d got %b/%b/%h want %b/%b/%h", c,
                         bus.o_valid, bus.o_btn, bus.o_sw_data, expValid, expBtn, expSw);
            end
        end
        total++;
        if (bus.o_sw_data !== 8'h11) begin
            bad++;
            $display("[TB] FAIL switch_hold got %h want 11", bus.o_sw_data);
        end
    endtask

    task automatic test_random();
        logic [NB_SEL-1:0] target;
        int len;
        logic prevValid;
        prevValid = 1'b0;
        applyReset();
        for (int seg = 0; seg < 70; seg++) begin
            target = NB_SEL'($urandom_range(0, 7));
            len    = $urandom_range(1, 16);
            for (int c = 0; c < len; c++) begin
                if (c < 3 && $urandom_range(0, 1) == 1)
                    applyStimulus(NB_SEL'($urandom), NB_DATA'($urandom));
                else
                    applyStimulus(target, NB_DATA'($urandom));
                tick();
                total++;
                if ({bus.o_valid, bus.o_btn, bus.o_sw_data} !== {expValid, expBtn, expSw}) begin
                    bad++;
                    $display("[TB] FAIL random seg=%0d c=%0d got %b/%b/%h want %b/%b/%h", seg, c,
                             bus.o_valid, bus.o_btn, bus.o_sw_data, expValid, expBtn, expSw);
                end
                if (prevValid) begin
                    total++;
                    if (bus.o_valid !== 1'b0) begin
                        bad++;
                        $display("[TB] FAIL random_strobe seg=%0d got %b want 0", seg, bus.o_valid);
                    end
                end
                prevValid = bus.o_valid;
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        i_rst_n = 1'b0;
        bus.i_btn_raw = '0;
        bus.i_sw_raw  = '0;
        modelReset();
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_simultaneous();
        test_reset_mid_press();
        test_switch_idle();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
